// File: rtl/reg_dump_tx.sv
// reg_dump_tx
//
// Dumps all 32 registers of a register file over a UART line when iStart
// is pulsed. Each register is selected through the register file's display
// read port, its value is captured once, and then its four bytes are sent
// most significant byte first as 8N1 frames (LSB first on the wire).
//
// Optional feature (compile-time macro):
//   REG_DUMP_HEADER_EN - when defined, a single 0xA5 sync byte is sent
//                        before x0, making a dump 129 bytes long.
//
// Parameters:
//   CLK_DIV          - iCLK cycles per UART bit (4..65535).
//
// Ports:
//   iCLK             - system clock, all state changes on its rising edge
//   iRST             - asynchronous active-high reset
//   iStart           - single-cycle dump request (accepted only when idle)
//   oRegDispSelect   - registered register index for the display read port
//   iRegDisp         - display read data for oRegDispSelect
//   oTx              - UART serial output, idles high
//   oBusy            - high while a dump is in progress
//   oDone            - one-cycle pulse once the last stop bit has been sent

module reg_dump_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    output logic [4:0]  oRegDispSelect,
    input  logic [31:0] iRegDisp,
    output logic        oTx,
    output logic        oBusy,
    output logic        oDone
);

    // Bit-period counter sized to hold CLK_DIV-1.
    localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

    // Frame bit index: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0] StopBit = 4'd9;
    localparam logic [3:0] LastData = 4'd8;
    localparam logic [4:0] LastReg = 5'd31;
    localparam logic [1:0] LastByte = 2'd3;

`ifdef REG_DUMP_HEADER_EN
    localparam logic [7:0] SyncByte = 8'hA5;
`endif

    if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("reg_dump_tx: CLK_DIV must be within 4..65535");
    end

    typedef enum logic [2:0] {
        StIdle,
`ifdef REG_DUMP_HEADER_EN
        StHdr,
`endif
        StSel,
        StCap,
        StByte,
        StNext,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [4:0]        sel_q, sel_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [3:0]        bit_q, bit_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic              tx_q, tx_d;

    logic              in_frame;
    logic              bit_end;
    logic              frame_end;
    logic [7:0]        word_byte;
    logic [7:0]        cur_byte;

    // Byte of the captured word currently on the wire, MSB byte first.
    always_comb begin
        word_byte = word_q[31:24];
        unique case (byte_q)
            2'd0: word_byte = word_q[31:24];
            2'd1: word_byte = word_q[23:16];
            2'd2: word_byte = word_q[15:8];
            2'd3: word_byte = word_q[7:0];
            default: word_byte = word_q[31:24];
        endcase
    end

`ifdef REG_DUMP_HEADER_EN
    assign cur_byte = (state_q == StHdr) ? SyncByte : word_byte;
    assign in_frame = (state_q == StByte) || (state_q == StHdr);
`else
    assign cur_byte = word_byte;
    assign in_frame = (state_q == StByte);
`endif

    assign bit_end   = (baud_q == BaudMax);
    assign frame_end = bit_end && (bit_q == StopBit);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        word_d  = word_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        tx_d    = tx_q;

        // Shared frame engine. The line value for the next bit is registered
        // at the bit boundary so oTx never glitches. The counter wraps to 0
        // on every boundary, so ten bits take exactly 10*CLK_DIV cycles.
        if (in_frame) begin
            if (!bit_end) begin
                baud_d = baud_q + 1'b1;
            end else begin
                baud_d = '0;
                if (bit_q != StopBit) begin
                    bit_d = bit_q + 1'b1;
                    // bit_q 0..7 moves onto data bit bit_q; bit_q 8 onto stop.
                    tx_d  = (bit_q == LastData) ? 1'b1 : cur_byte[bit_q[2:0]];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (iStart) begin
                    idx_d = '0;
`ifdef REG_DUMP_HEADER_EN
                    // Sync byte start bit goes out straight away.
                    state_d = StHdr;
                    bit_d   = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
`else
                    state_d = StSel;
`endif
                end
            end
`ifdef REG_DUMP_HEADER_EN
            StHdr: begin
                if (frame_end) begin
                    state_d = StSel;
                    tx_d    = 1'b1;
                end
            end
`endif
            StSel: begin
                state_d = StCap;
            end
            StCap: begin
                // Capture once; later register writes cannot reach the wire.
                word_d  = iRegDisp;
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = StByte;
            end
            StByte: begin
                if (frame_end) begin
                    if (byte_q == LastByte) begin
                        state_d = StNext;
                        tx_d    = 1'b1;
                    end else begin
                        // Back-to-back frames: next start bit follows the stop bit.
                        byte_d = byte_q + 1'b1;
                        bit_d  = '0;
                        tx_d   = 1'b0;
                    end
                end
            end
            StNext: begin
                tx_d = 1'b1;
                if (idx_q == LastReg) begin
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StSel;
                end
            end
            StFin: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Display select is updated only on entry to SEL and otherwise holds.
        if (state_d == StSel) begin
            sel_d = idx_d;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
        end
    end

    assign oRegDispSelect = sel_q;
    assign oTx            = tx_q;
    assign oBusy          = (state_q != StIdle) && (state_q != StFin);
    assign oDone          = (state_q == StFin);

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

    localparam int D = 4;
`ifdef REG_DUMP_HEADER_EN
    localparam int ExpBytes = 129;
`else
    localparam int ExpBytes = 128;
`endif
    localparam int DumpBudget = 12 * D * ExpBytes + 1000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iStart = 1'b0;
    logic [4:0]  oRegDispSelect;
    logic [31:0] iRegDisp;
    logic        oTx;
    logic        oBusy;
    logic        oDone;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int rx_count = 0;

    always #5 iCLK = ~iCLK;

    // Asynchronous register file display port.
    assign iRegDisp = regs[oRegDispSelect];

    reg_dump_tx #(
        .CLK_DIV(D)
    ) dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iStart        (iStart),
        .oRegDispSelect(oRegDispSelect),
        .iRegDisp      (iRegDisp),
        .oTx           (oTx),
        .oBusy         (oBusy),
        .oDone         (oDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a dump of the current file must put on the wire.
    task automatic push_expected();
`ifdef REG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int r = 0; r < 32; r++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
            end
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic randomize_regs();
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
    endtask

    // ---------------------------------------------------------------- monitor
    // UART receiver sampling every negedge. Each bit period must be constant
    // for exactly D samples, frames are decoded and popped against exp_q.
    int         m_c = 0;
    int         m_gap = 0;
    bit         m_active = 0;
    bit         m_prev = 0;
    bit         m_bad = 0;
    logic [9:0] m_bits;

    always @(negedge iCLK) begin
        if (iRST) begin
            m_active = 0;
            m_prev   = 0;
            m_gap    = 0;
        end else if (!m_active) begin
            if (oTx == 1'b0) begin
                if (m_prev) begin
                    n_checks++;
                    if (m_gap > 2 * D) begin
                        n_fail++;
                        $display("FAIL frame_gap: got %0d idle cycles, required at most %0d",
                                 m_gap, 2 * D);
                    end
                end
                m_active  = 1;
                m_bad     = 0;
                m_bits    = '0;
                m_bits[0] = 1'b0;
                m_c       = 1;
            end else if (oBusy) begin
                m_gap++;
            end else begin
                m_prev = 0;
                m_gap  = 0;
            end
        end else begin
            if (m_c % D == 0) m_bits[m_c / D] = oTx;
            else if (oTx !== m_bits[m_c / D]) m_bad = 1;
            m_c++;
            if (m_c == 10 * D) begin
                m_active = 0;
                m_prev   = 1;
                m_gap    = 0;
                rx_count++;
                check("frame_shape", 32'(m_bad), 32'd0);
                check("stop_bit", 32'(m_bits[9]), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(m_bits[8:1]), 32'h100);
                end else begin
                    check("rx_byte", 32'(m_bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    // mode 0: plain, 1: iStart re-pulsed at byte 50, 2: x5 rewritten after
    // its capture, 3: iStart in the oDone cycle must be ignored.
    task automatic run_dump(input int mode);
        int cyc = 0;
        int busy_bad = 0;
        int sel5 = -1;
        int bad = 0;
        bit restarted = 0;

        push_expected();
        rx_count = 0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        while (!oDone && cyc < DumpBudget) begin
            if (!oBusy) busy_bad++;
            if (mode == 1 && !restarted && rx_count >= 50) begin
                iStart    = 1'b1;
                restarted = 1;
            end else begin
                iStart = 1'b0;
            end
            if (mode == 2) begin
                if (sel5 < 0 && oRegDispSelect == 5'd5) sel5 = cyc;
                if (sel5 >= 0 && cyc == sel5 + 2) regs[5] = 32'h5555_5555;
            end
            step();
            cyc++;
        end
        iStart = 1'b0;
        check("done_seen", 32'(oDone), 32'd1);
        check("busy_during_dump", 32'(busy_bad), 32'd0);
        check("busy_at_done", 32'(oBusy), 32'd0);
        check("byte_count", 32'(rx_count), 32'(ExpBytes));
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        if (mode == 3) iStart = 1'b1;
        step();
        iStart = 1'b0;
        check("done_one_cycle", 32'(oDone), 32'd0);
        for (int i = 0; i < 3 * D; i++) begin
            if (oBusy || !oTx || oDone) bad++;
            step();
        end
        check("idle_after_dump", 32'(bad), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_reset_abort();
        int cyc = 0;
        int bad = 0;

        push_expected();
        rx_count = 0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        while (rx_count < 10 && cyc < DumpBudget) begin
            step();
            cyc++;
        end
        while (oTx !== 1'b0 && cyc < DumpBudget) begin
            step();
            cyc++;
        end
        check("reach_byte10", 32'(cyc < DumpBudget), 32'd1);
        repeat (3 * D + 1) step();
        #2;
        iRST = 1'b1;
        #1;
        check("rst_async_tx", 32'(oTx), 32'd1);
        check("rst_async_busy", 32'(oBusy), 32'd0);
        check("rst_async_done", 32'(oDone), 32'd0);
        check("rst_async_sel", 32'(oRegDispSelect), 32'd0);
        step();
        step();
        iRST = 1'b0;
        exp_q.delete();
        rx_count = 0;
        for (int i = 0; i < 10 * D; i++) begin
            if (oBusy || !oTx) bad++;
            step();
        end
        check("no_resume_after_rst", 32'(bad), 32'd0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = '0;
        #2;
        iRST = 1'b1;
        #2;
        check("reset_tx", 32'(oTx), 32'd1);
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_done", 32'(oDone), 32'd0);
        check("reset_sel", 32'(oRegDispSelect), 32'd0);
        step();
        step();
        iRST = 1'b0;
        step();

        // Known pattern: x1 = 0x12345678, everything else zero.
        regs[1] = 32'h1234_5678;
        run_dump(0);

        randomize_regs();
        run_dump(1);

        randomize_regs();
        regs[5] = 32'hAAAA_AAAA;
        run_dump(2);

        randomize_regs();
        run_reset_abort();

        randomize_regs();
        run_dump(3);

        randomize_regs();
        run_dump(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
